// File: rtl/dst_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// dst_writeback_arbiter
//
// Round-robin write-back controller for the CPU register file. Four
// destination sources (mux inputs A..D: ALU, memory load, immediate, PC link)
// compete for the single register-file write port. The winner's mux select
// and destination address are latched, the mux is given one GRANT cycle to
// settle, then a one-cycle WRITE strobe and acknowledge are issued.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   req[3:0]       write requests, bit i = mux input i (0=A .. 3=D)
//   wb_reg_a..d    destination register of each requester (stable while req)
//   flush          cancels a grant that has not yet been written
//   dst_selection  destination mux select (registered)
//   wb_en          register-file write strobe (registered)
//   wb_addr        register-file write address (registered)
//   ack[3:0]       one-hot, one-cycle acknowledge, coincides with wb_en
//   busy           high while in GRANT or WRITE
//   wb_count       completed-write counter, wraps silently
// ---------------------------------------------------------------------------
module dst_writeback_arbiter #(
   parameter int ADDR_W = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        req,
   input  logic [ADDR_W-1:0] wb_reg_a,
   input  logic [ADDR_W-1:0] wb_reg_b,
   input  logic [ADDR_W-1:0] wb_reg_c,
   input  logic [ADDR_W-1:0] wb_reg_d,
   input  logic              flush,
   output logic [1:0]        dst_selection,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [3:0]        ack,
   output logic              busy,
   output logic [CNT_W-1:0]  wb_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t            state;
   logic [1:0]        ptr;

   logic [3:0]        elig;
   logic [1:0]        start;
   logic [2:0]        pick;
   logic              found;
   logic [1:0]        winner;
   logic [ADDR_W-1:0] winner_reg;

   // Returns {found, index} of the first set bit of elig at or after start,
   // wrapping modulo 4. The loop runs from the farthest offset down so the
   // nearest hit is the one that sticks.
   function automatic logic [2:0] rr_pick(input logic [3:0] e, input logic [1:0] s);
      logic [1:0] idx;
      rr_pick = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = s + 2'(k);
         if (e[idx]) rr_pick = {1'b1, idx};
      end
   endfunction

   // Arbitration is shared by IDLE and WRITE. In WRITE the requester being
   // served is masked (it may still show req this cycle) and the search
   // starts from the pointer value that this edge will install.
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      elig  = req;
      start = ptr;
      if (state == WRITE) begin
         elig  = req & ~(4'b0001 << dst_selection);
         start = dst_selection + 2'd1;
      end
      pick   = rr_pick(elig, start);
      found  = pick[2];
      winner = pick[1:0];
      case (winner)
         2'd0:    winner_reg = wb_reg_a;
         2'd1:    winner_reg = wb_reg_b;
         2'd2:    winner_reg = wb_reg_c;
         default: winner_reg = wb_reg_d;
      endcase
   end

   assign busy = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ptr           <= 2'd0;
         dst_selection <= 2'd0;
         wb_en         <= 1'b0;
         wb_addr       <= '0;
         ack           <= 4'b0000;
         wb_count      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  dst_selection <= winner;
                  wb_addr       <= winner_reg;
                  state         <= GRANT;
               end
            end
            GRANT: begin
               // A flushed grant leaves the pointer alone, so the same
               // requester wins again if it is still asking.
               if (flush) begin
                  state <= IDLE;
               end else begin
                  wb_en <= 1'b1;
                  ack   <= 4'b0001 << dst_selection;
                  state <= WRITE;
               end
            end
            WRITE: begin
               // The register file captures on this edge; flush has no
               // effect here so an in-flight write always completes.
               wb_en    <= 1'b0;
               ack      <= 4'b0000;
               wb_count <= wb_count + CNT_W'(1);
               ptr      <= dst_selection + 2'd1;
               if (found) begin
                  dst_selection <= winner;
                  wb_addr       <= winner_reg;
                  state         <= GRANT;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dst_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dst_writeback_arbiter
//
// Directed scenarios for the write-back arbiter followed by a randomized run
// against a transaction-level model. A second instance with a 4-bit counter
// shares all inputs and is used for the counter wrap checks.
// ---------------------------------------------------------------------------
module tb_dst_writeback_arbiter;

   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [3:0]        req;
   logic              flush;
   logic [ADDR_W-1:0] stim_reg [4];
   logic [ADDR_W-1:0] wb_reg_a, wb_reg_b, wb_reg_c, wb_reg_d;

   logic [1:0]        dst_selection;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [3:0]        ack;
   logic              busy;
   logic [15:0]       wb_count;

   logic [1:0]        s_dst_selection;
   logic              s_wb_en;
   logic [ADDR_W-1:0] s_wb_addr;
   logic [3:0]        s_ack;
   logic              s_busy;
   logic [3:0]        s_wb_count;

   int n_checks = 0;
   int n_fail   = 0;

   assign wb_reg_a = stim_reg[0];
   assign wb_reg_b = stim_reg[1];
   assign wb_reg_c = stim_reg[2];
   assign wb_reg_d = stim_reg[3];

   always #5 clk = ~clk;

   dst_writeback_arbiter #(.ADDR_W(ADDR_W), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .wb_reg_a(wb_reg_a), .wb_reg_b(wb_reg_b), .wb_reg_c(wb_reg_c), .wb_reg_d(wb_reg_d),
      .flush(flush), .dst_selection(dst_selection), .wb_en(wb_en), .wb_addr(wb_addr),
      .ack(ack), .busy(busy), .wb_count(wb_count)
   );

   dst_writeback_arbiter #(.ADDR_W(ADDR_W), .CNT_W(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .req(req),
      .wb_reg_a(wb_reg_a), .wb_reg_b(wb_reg_b), .wb_reg_c(wb_reg_c), .wb_reg_d(wb_reg_d),
      .flush(flush), .dst_selection(s_dst_selection), .wb_en(s_wb_en), .wb_addr(s_wb_addr),
      .ack(s_ack), .busy(s_busy), .wb_count(s_wb_count)
   );

   // Advance one clock; outputs are then looked at 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      flush = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // ------------------------------------------------------------------
   // Reference model: one pending transaction at a time. A transaction is
   // picked round-robin, spends one cycle granted (where flush may drop
   // it) and one cycle being written; the served requester cannot win the
   // pick made at the end of its own write.
   // ------------------------------------------------------------------
   int m_phase;   // 0 nothing pending, 1 granted, 2 being written
   int m_ptr, m_sel, m_addr, m_en, m_ack, m_count;

   function automatic int rr_first(input int elig, input int from);
      for (int k = 0; k < 4; k++)
         if (elig[(from + k) % 4]) return (from + k) % 4;
      return -1;
   endfunction

   function automatic void m_reset();
      m_phase = 0; m_ptr = 0; m_sel = 0; m_addr = 0; m_en = 0; m_ack = 0; m_count = 0;
   endfunction

   function automatic void m_take(input int w);
      m_sel   = w;
      m_addr  = int'(stim_reg[w]);
      m_phase = 1;
   endfunction

   function automatic void m_step(input int r, input int f);
      int w;
      if (m_phase == 0) begin
         w = rr_first(r, m_ptr);
         if (w >= 0) m_take(w);
      end else if (m_phase == 1) begin
         if (f != 0) m_phase = 0;
         else begin m_en = 1; m_ack = 1 << m_sel; m_phase = 2; end
      end else begin
         m_en = 0; m_ack = 0; m_count++;
         m_ptr = (m_sel + 1) % 4;
         w = rr_first(r & ~(1 << m_sel), m_ptr);
         if (w >= 0) m_take(w);
         else m_phase = 0;
      end
   endfunction

   // ------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0; req = 4'b0000; flush = 1'b0;
      for (int i = 0; i < 4; i++) stim_reg[i] = '0;
      #2;
      n_checks++;
      if ({dst_selection, wb_en, wb_addr, ack, busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got sel=%0d en=%0d addr=%0d ack=%b busy=%0d required all zero",
                  dst_selection, wb_en, wb_addr, ack, busy);
      end
      n_checks++;
      if (wb_count !== 16'd0 || s_wb_count !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_count got %0d/%0d required 0/0", wb_count, s_wb_count);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      stim_reg[1] = 3'd5;
      req = 4'b0010;
      tick();
      n_checks++;
      if (dst_selection !== 2'd1 || wb_addr !== 3'd5 || wb_en !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_grant got sel=%0d addr=%0d en=%0d busy=%0d required 1,5,0,1",
                  dst_selection, wb_addr, wb_en, busy);
      end
      tick();
      n_checks++;
      if (wb_en !== 1'b1 || ack !== 4'b0010 || dst_selection !== 2'd1) begin
         n_fail++;
         $display("FAIL single_write got en=%0d ack=%b sel=%0d required 1,0010,1", wb_en, ack, dst_selection);
      end
      req = 4'b0000;
      tick();
      n_checks++;
      if (wb_en !== 1'b0 || ack !== 4'b0000 || wb_count !== 16'd1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done got en=%0d ack=%b count=%0d busy=%0d required 0,0000,1,0",
                  wb_en, ack, wb_count, busy);
      end
      tick();
      n_checks++;
      if (busy !== 1'b0 || wb_addr !== 3'd5 || dst_selection !== 2'd1) begin
         n_fail++;
         $display("FAIL single_hold got busy=%0d addr=%0d sel=%0d required 0,5,1", busy, wb_addr, dst_selection);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_sel;
      logic [3:0] exp_ack;
      do_reset();
      for (int i = 0; i < 4; i++) stim_reg[i] = 3'(i + 1);
      req = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         exp_sel = 2'(k % 4);
         exp_ack = 4'b0001 << exp_sel;
         n_checks++;
         if (dst_selection !== exp_sel || wb_addr !== 3'(exp_sel + 1) || wb_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_grant%0d got sel=%0d addr=%0d en=%0d required %0d,%0d,0",
                     k, dst_selection, wb_addr, wb_en, exp_sel, exp_sel + 1);
         end
         tick();
         n_checks++;
         if (wb_en !== 1'b1 || ack !== exp_ack) begin
            n_fail++;
            $display("FAIL rr_write%0d got en=%0d ack=%b required 1,%b", k, wb_en, ack, exp_ack);
         end
         tick();
      end
      req = 4'b0000;
   endtask

   task automatic test_mask();
      do_reset();
      stim_reg[0] = 3'd7;
      req = 4'b0001;
      for (int c = 1; c <= 9; c++) begin
         tick();
         n_checks++;
         if (wb_en !== (c % 3 == 2) || ack !== ((c % 3 == 2) ? 4'b0001 : 4'b0000)
             || busy !== (c % 3 != 0)) begin
            n_fail++;
            $display("FAIL mask_cycle%0d got en=%0d ack=%b busy=%0d required %0d,%0d,%0d",
                     c, wb_en, ack, busy, c % 3 == 2, c % 3 == 2, c % 3 != 0);
         end
      end
      req = 4'b0000;
   endtask

   task automatic test_flush_grant();
      do_reset();
      stim_reg[1] = 3'd2; stim_reg[2] = 3'd6;
      req = 4'b0010;                       // serve B first so the pointer sits at C
      tick(); tick();
      req = 4'b0000;
      tick();
      req = 4'b0100;
      tick();                              // GRANT for C
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_checks++;
      if (wb_en !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || wb_count !== 16'd1) begin
         n_fail++;
         $display("FAIL flush_grant got en=%0d ack=%b busy=%0d count=%0d required 0,0000,0,1",
                  wb_en, ack, busy, wb_count);
      end
      req = 4'b1101;                       // C competes with D and A
      tick();
      n_checks++;
      if (dst_selection !== 2'd2 || wb_addr !== 3'd6) begin
         n_fail++;
         $display("FAIL flush_ptr got sel=%0d addr=%0d required 2,6", dst_selection, wb_addr);
      end
      tick();
      n_checks++;
      if (wb_en !== 1'b1 || ack !== 4'b0100) begin
         n_fail++;
         $display("FAIL flush_regrant got en=%0d ack=%b required 1,0100", wb_en, ack);
      end
      req = 4'b0000;
      tick();
      n_checks++;
      if (wb_count !== 16'd2) begin
         n_fail++;
         $display("FAIL flush_count got %0d required 2", wb_count);
      end
   endtask

   task automatic test_flush_write_and_reset();
      do_reset();
      stim_reg[0] = 3'd3; stim_reg[1] = 3'd4;
      req = 4'b0001;
      tick(); tick();                      // now in WRITE
      flush = 1'b1;
      req   = 4'b0000;
      tick();
      flush = 1'b0;
      n_checks++;
      if (wb_count !== 16'd1 || wb_en !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_write got count=%0d en=%0d required 1,0", wb_count, wb_en);
      end
      req = 4'b0010;
      tick();                              // GRANT for B
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({dst_selection, wb_en, wb_addr, ack, busy} !== '0 || wb_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_midop got sel=%0d en=%0d addr=%0d ack=%b busy=%0d count=%0d required all zero",
                  dst_selection, wb_en, wb_addr, ack, busy, wb_count);
      end
      req = 4'b0000;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (wb_en !== 1'b0 || ack !== 4'b0000 || wb_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_release%0d got en=%0d ack=%b count=%0d required 0,0000,0",
                     c, wb_en, ack, wb_count);
         end
      end
   endtask

   task automatic test_counter_wrap();
      do_reset();
      req = 4'b0011;
      tick();                              // first GRANT
      for (int n = 1; n <= 17; n++) begin
         tick();                           // WRITE
         tick();                           // write captured
         n_checks++;
         if (s_wb_count !== 4'(n % 16) || wb_count !== 16'(n)) begin
            n_fail++;
            $display("FAIL wrap_write%0d got small=%0d wide=%0d required %0d,%0d",
                     n, s_wb_count, wb_count, n % 16, n);
         end
      end
      req = 4'b0000;
      tick(); tick();
   endtask

   task automatic test_random();
      logic [3:0] pend;
      do_reset();
      m_reset();
      pend = 4'b0000;
      for (int c = 0; c < 400; c++) begin
         // Requesters retire on acknowledge (or keep asking) and only
         // change their destination when raising a fresh request.
         for (int i = 0; i < 4; i++) begin
            if (pend[i] && m_ack[i] && $urandom_range(1, 0) == 0) pend[i] = 1'b0;
            else if (!pend[i] && $urandom_range(2, 0) == 0) begin
               pend[i]     = 1'b1;
               stim_reg[i] = 3'($urandom);
            end
         end
         req   = pend;
         flush = ($urandom_range(4, 0) == 0);
         tick();
         m_step(int'(req), int'(flush));
         n_checks++;
         if (dst_selection !== 2'(m_sel) || wb_addr !== 3'(m_addr)) begin
            n_fail++;
            $display("FAIL rand%0d_select got sel=%0d addr=%0d required %0d,%0d",
                     c, dst_selection, wb_addr, m_sel, m_addr);
         end
         n_checks++;
         if (wb_en !== 1'(m_en) || ack !== 4'(m_ack) || busy !== (m_phase != 0)) begin
            n_fail++;
            $display("FAIL rand%0d_strobe got en=%0d ack=%b busy=%0d required %0d,%b,%0d",
                     c, wb_en, ack, busy, m_en, 4'(m_ack), m_phase != 0);
         end
         n_checks++;
         if (wb_count !== 16'(m_count) || s_wb_count !== 4'(m_count % 16)) begin
            n_fail++;
            $display("FAIL rand%0d_count got %0d/%0d required %0d/%0d",
                     c, wb_count, s_wb_count, m_count, m_count % 16);
         end
      end
      req = 4'b0000; flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_mask();
      test_flush_grant();
      test_flush_write_and_reset();
      test_counter_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dst_writeback_arbiter.md
# dst_writeback_arbiter

Round-robin write-back controller for the CPU register file. It arbitrates among four destination sources, the ones wired to inputs A–D of the destination mux: ALU, memory load, immediate, and PC link. It drives the mux's 2-bit destination select and then issues a one-cycle register-file write strobe with the winning destination address. Each write takes a fixed two-cycle grant/write sequence, and every requester receives a one-cycle acknowledge.

## Interface
- ADDR_W, 3, register-file address width
- CNT_W, 16, width of the completed-write counter
- CLK  input  1  single system clock, rising edge
- RST_N  input  1  asynchronous, active-low reset
- REQ  input  4  write requests; bit i corresponds to mux input i (0=A … 3=D)
- WB_REG_A, WB_REG_B, WB_REG_C, WB_REG_D  input  ADDR_W each  destination register of requester A/B/C/D; held stable while its REQ is high
- FLUSH  input  1  synchronous cancel of a grant not yet written
- DST_SELECTION  output  2  select for the destination mux (registered)
- WB_EN  output  1  register-file write strobe (registered)
- WB_ADDR  output  ADDR_W  register-file write address (registered)
- ACK  output  4  one-hot, one-cycle acknowledge to the served requester (registered)
- BUSY  output  1  high in GRANT or WRITE
- WB_COUNT  output  CNT_W  number of completed writes, wraps modulo 2^CNT_W

## Operation
- One clock; reset is asynchronous and active-low.
- Reset values (RST_N low, immediate):
  - state IDLE, round-robin pointer PTR=0
  - DST_SELECTION=0, WB_EN=0, WB_ADDR=0, ACK=0, BUSY=0, WB_COUNT=0.
- Arbitration: the winner is the first set bit of the eligible REQ, searching from PTR upward modulo 4.
- FSM states are IDLE, GRANT and WRITE.
- IDLE:
  - If REQ≠0, latch winner W into DST_SELECTION and WB_REG_W into WB_ADDR, then go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: the mux output settles this cycle.
  - FLUSH=1: go to IDLE. No write, no ACK, PTR unchanged.
  - Otherwise set WB_EN=1 and ACK[W]=1, then go to WRITE.
- WRITE: the register file captures mux output and WB_ADDR on the closing edge. On that edge:
  - WB_EN and ACK clear; WB_COUNT increments; PTR becomes (W+1) mod 4.
  - Re-arbitrate with bit W masked, because the served requester may still show REQ this cycle.
  - If another request is present, latch the new winner and go directly to GRANT; otherwise go to IDLE.
  - FLUSH is ignored in WRITE: a write in flight always completes.
- REQ dropped by a requester while it is in GRANT: the write still completes. Requesters must not withdraw; this is a bench check, not handled by the design.
- DST_SELECTION and WB_ADDR hold their last values in IDLE.

## Timing
- Latency from REQ seen in IDLE at cycle n: GRANT at n+1, WB_EN and ACK high during n+2, write captured at the end of n+2.
- Sustained throughput is one write per 2 cycles (GRANT→WRITE→GRANT…).
- ACK is exactly one cycle wide and coincides with WB_EN.
- The requester samples ACK at the end of the WRITE cycle and may present its next request from the following cycle.
- DST_SELECTION is stable for the whole GRANT and WRITE cycles and never changes while WB_EN=1.
- WB_COUNT wraps from 2^CNT_W−1 to 0 with no flag.
- Async reset during GRANT or WRITE aborts immediately: WB_EN and ACK drop with no partial write after release.
- Reset deassertion must be synchronized externally; the block only requires the asynchronous assertion path.

## Test plan
- Single request: reset, then REQ=0010 with WB_REG_B=5. Expect DST_SELECTION=1 and WB_ADDR=5 at cycle 1, WB_EN=1 and ACK=0010 at cycle 2, WB_COUNT=1, then IDLE.
- Round-robin fairness:
  - REQ=1111 held, requesters hold REQ after ACK.
  - Expect grant order 0,1,2,3,0 with WB_EN high every other cycle and ACK one-hot each time.
- Masking after WRITE: REQ=0001 held continuously.
  - Expect A served every 3 cycles (WRITE→IDLE→GRANT), never back-to-back from WRITE.
- FLUSH in GRANT: REQ=0100, FLUSH=1 in the GRANT cycle.
  - Expect no WB_EN, ACK=0, WB_COUNT unchanged; next grant still goes to C (PTR unchanged).
- FLUSH in WRITE and reset mid-operation:
  - FLUSH asserted in WRITE: write completes and WB_COUNT increments.
  - RST_N low during GRANT: all outputs are reset values in the same cycle, and no WB_EN after release.
- Counter wrap: with CNT_W=4, perform 17 writes. Expect WB_COUNT sequence …15,0,1.
